aes_ctr_req: RTL and testbench



---
 rtl/aes_pkg.sv | 26 ++
 rtl/aes_ctr_req_chk.sv | 40 ++++
 rtl/aes_ctr_req.sv | 150 +++++++++++++++
 tb/tb_aes_ctr_req.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and constants: sparse two-valued signals, counter slicing,
// and the state encoding of the CTR increment requester.
package aes_pkg;

  typedef enum logic [2:0] {
    SP2V_HIGH = 3'b011,
    SP2V_LOW  = 3'b100
  } sp2v_e;

  localparam int NumSlicesCtr  = 8;
  localparam int SliceSizeCtr  = 16;
  localparam int SliceIdxWidth = $clog2(NumSlicesCtr);

  // Slice 0 is the most significant; slice NumSlicesCtr-1 holds the LSBs.
  typedef logic [0:NumSlicesCtr-1][SliceSizeCtr-1:0] ctr_slices_t;

  // Pairwise Hamming distance >= 3 so a single flipped bit cannot alias a state.
  typedef enum logic [5:0] {
    CTR_REQ_IDLE  = 6'b100100,
    CTR_REQ_REQ   = 6'b010010,
    CTR_REQ_BUSY  = 6'b001111,
    CTR_REQ_DONE  = 6'b111001,
    CTR_REQ_ERROR = 6'b000001
  } aes_ctr_req_e;

endpackage

// File: rtl/aes_ctr_req_chk.sv
// Combinational protocol checker over the counter's ready and per-slice write enables.
module aes_ctr_req_chk
  import aes_pkg::*;
(
  input  sp2v_e                    ready_i,
  input  sp2v_e                    ctr_we_i [NumSlicesCtr],
  output logic                     sp2v_err_o,
  output logic                     multi_we_err_o,
  output logic [SliceIdxWidth-1:0] we_idx_o,
  output logic                     we_valid_o
);

  logic                     sp2vErr;
  logic                     seenWe;
  logic                     multiWe;
  logic [SliceIdxWidth-1:0] weIdx;

  always_comb begin
    sp2vErr = (ready_i != SP2V_HIGH) && (ready_i != SP2V_LOW);
    seenWe  = 1'b0;
    multiWe = 1'b0;
    weIdx   = '0;
    for (int k = 0; k < NumSlicesCtr; k++) begin
      if ((ctr_we_i[k] != SP2V_HIGH) && (ctr_we_i[k] != SP2V_LOW)) begin
        sp2vErr = 1'b1;
      end
      if (ctr_we_i[k] == SP2V_HIGH) begin
        multiWe = multiWe | seenWe;
        seenWe  = 1'b1;
        weIdx   = SliceIdxWidth'(k);
      end
    end
  end

  assign sp2v_err_o     = sp2vErr;
  assign multi_we_err_o = multiWe;
  assign we_idx_o       = weIdx;
  assign we_valid_o     = seenWe & ~multiWe;

endmodule

// File: rtl/aes_ctr_req.sv
// Requester side of the AES CTR increment handshake: owns the counter register,
// captures the counter's sliced write-backs and locks up on any protocol violation.
module aes_ctr_req
  import aes_pkg::*;
#(
  parameter int TimeoutCycles = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 req_i,
  input  logic                                 load_i,
  input  logic [NumSlicesCtr*SliceSizeCtr-1:0] load_data_i,
  output logic                                 ack_o,
  output logic                                 busy_o,
  output logic [NumSlicesCtr*SliceSizeCtr-1:0] ctr_q_o,
  output sp2v_e                                incr_o,
  input  sp2v_e                                ready_i,
  output ctr_slices_t                          ctr_o,
  input  ctr_slices_t                          ctr_i,
  input  sp2v_e                                ctr_we_i [NumSlicesCtr],
  output logic                                 alert_o
);

  localparam int TimerWidth = $clog2(TimeoutCycles + 1);
  localparam int WrCntWidth = $clog2(NumSlicesCtr + 1);

  aes_ctr_req_e             state_q, state_d;
  ctr_slices_t              ctr_q, ctr_d;
  logic [SliceIdxWidth-1:0] exp_idx_q, exp_idx_d;
  logic [WrCntWidth-1:0]    wr_cnt_q, wr_cnt_d;
  logic [TimerWidth-1:0]    timer_q, timer_d;
  logic                     ready_low_seen_q, ready_low_seen_d;

  logic                     sp2vErr, multiWeErr, weValid, err;
  logic [SliceIdxWidth-1:0] weIdx;

  aes_ctr_req_chk u_chk (
    .ready_i        (ready_i),
    .ctr_we_i       (ctr_we_i),
    .sp2v_err_o     (sp2vErr),
    .multi_we_err_o (multiWeErr),
    .we_idx_o       (weIdx),
    .we_valid_o     (weValid)
  );

  always_comb begin
    state_d          = state_q;
    ctr_d            = ctr_q;
    exp_idx_d        = exp_idx_q;
    wr_cnt_d         = wr_cnt_q;
    timer_d          = timer_q;
    ready_low_seen_d = ready_low_seen_q;
    err              = sp2vErr | multiWeErr;

    if (weValid && (state_q != CTR_REQ_BUSY)) begin
      err = 1'b1;
    end

    if ((state_q == CTR_REQ_REQ) || (state_q == CTR_REQ_BUSY)) begin
      if (timer_q == TimerWidth'(TimeoutCycles - 1)) begin
        err = 1'b1;
      end
      if (timer_q != TimerWidth'(TimeoutCycles)) begin
        timer_d = timer_q + 1'b1;
      end
    end

    unique case (state_q)
      CTR_REQ_IDLE: begin
        if (load_i) begin
          ctr_d = load_data_i;
        end else if (req_i) begin
          state_d = CTR_REQ_REQ;
        end
      end
      CTR_REQ_REQ: begin
        if (ready_i == SP2V_HIGH) begin
          state_d = CTR_REQ_BUSY;
        end
      end
      CTR_REQ_BUSY: begin
        if (ready_i == SP2V_LOW) begin
          ready_low_seen_d = 1'b1;
        end
        if (weValid) begin
          if ((weIdx != exp_idx_q) || (wr_cnt_q == WrCntWidth'(NumSlicesCtr))) begin
            err = 1'b1;
          end else begin
            ctr_d[weIdx] = ctr_i[weIdx];
            exp_idx_d    = exp_idx_q - 1'b1;
            wr_cnt_d     = wr_cnt_q + 1'b1;
          end
        end
        // Completion needs the counter to have dropped ready at least once.
        if ((ready_i == SP2V_HIGH) && ready_low_seen_q) begin
          if (wr_cnt_q == '0) begin
            err = 1'b1;
          end else begin
            state_d = CTR_REQ_DONE;
          end
        end
      end
      CTR_REQ_DONE: begin
        exp_idx_d        = SliceIdxWidth'(NumSlicesCtr - 1);
        wr_cnt_d         = '0;
        timer_d          = '0;
        ready_low_seen_d = 1'b0;
        state_d          = CTR_REQ_IDLE;
      end
      CTR_REQ_ERROR: begin
        state_d = CTR_REQ_ERROR;
      end
      default: begin
        err = 1'b1;
      end
    endcase

    if (err) begin
      state_d = CTR_REQ_ERROR;
      ctr_d   = ctr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= CTR_REQ_IDLE;
      ctr_q            <= '0;
      exp_idx_q        <= SliceIdxWidth'(NumSlicesCtr - 1);
      wr_cnt_q         <= '0;
      timer_q          <= '0;
      ready_low_seen_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      ctr_q            <= ctr_d;
      exp_idx_q        <= exp_idx_d;
      wr_cnt_q         <= wr_cnt_d;
      timer_q          <= timer_d;
      ready_low_seen_q <= ready_low_seen_d;
    end
  end

  assign incr_o  = (state_q == CTR_REQ_REQ) ? SP2V_HIGH : SP2V_LOW;
  assign ack_o   = (state_q == CTR_REQ_DONE);
  assign busy_o  = (state_q == CTR_REQ_REQ) || (state_q == CTR_REQ_BUSY) ||
                   (state_q == CTR_REQ_DONE);
  assign alert_o = (state_q == CTR_REQ_ERROR);
  assign ctr_o   = ctr_q;
  assign ctr_q_o = ctr_q;

endmodule

// File: tb/tb_aes_ctr_req.sv
// Scoreboard bench for aes_ctr_req with a behavioural aes_ctr stub that can
// also be told to misbehave.
module tb_aes_ctr_req;
  import aes_pkg::*;

  localparam int TimeoutCycles = 32;

  typedef enum int {MODE_NORMAL, MODE_HOLD, MODE_NOREADY, MODE_SKIP, MODE_DOUBLE} stubMode_e;

  logic        clk = 1'b0;
  logic        rstI, reqI, loadI;
  logic [127:0] loadData;
  logic        ackO, busyO, alertO;
  logic [127:0] ctrQ;
  sp2v_e       incrO;
  sp2v_e       readyIn;
  ctr_slices_t ctrO;
  ctr_slices_t ctrIn;
  sp2v_e       ctrWe [NumSlicesCtr];

  stubMode_e   stubMode;
  sp2v_e       holdReady;
  int          holdWeIdx;
  logic [15:0] holdVal;
  int          phase;
  int          stubIdx;
  ctr_slices_t stubCtr;
  logic [15:0] newSlice;
  int          weIdx;

  logic [127:0] expQ [$];
  int           incrCycles;
  int           vectors = 0;
  int           miscompares = 0;

  always #5 clk = ~clk;

  aes_ctr_req #(.TimeoutCycles(TimeoutCycles)) dut (
    .clk_i       (clk),
    .rst_i       (rstI),
    .req_i       (reqI),
    .load_i      (loadI),
    .load_data_i (loadData),
    .ack_o       (ackO),
    .busy_o      (busyO),
    .ctr_q_o     (ctrQ),
    .incr_o      (incrO),
    .ready_i     (readyIn),
    .ctr_o       (ctrO),
    .ctr_i       (ctrIn),
    .ctr_we_i    (ctrWe),
    .alert_o     (alertO)
  );

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Counter stub: increments from the LSB slice, one slice write per cycle,
  // stopping once a slice does not carry out.
  always @(negedge clk) begin
    if (rstI) begin
      phase   = 0;
      readyIn = SP2V_HIGH;
      for (int k = 0; k < NumSlicesCtr; k++) ctrWe[k] = SP2V_LOW;
    end else if (stubMode == MODE_HOLD) begin
      readyIn = holdReady;
      for (int k = 0; k < NumSlicesCtr; k++) ctrWe[k] = SP2V_LOW;
      if (holdWeIdx >= 0) begin
        ctrWe[holdWeIdx] = SP2V_HIGH;
        ctrIn[holdWeIdx] = holdVal;
      end
    end else begin
      for (int k = 0; k < NumSlicesCtr; k++) ctrWe[k] = SP2V_LOW;
      case (phase)
        0: begin
          readyIn = (stubMode == MODE_NOREADY) ? SP2V_LOW : SP2V_HIGH;
          if (incrO == SP2V_HIGH && readyIn == SP2V_HIGH) begin
            phase   = 1;
            stubCtr = ctrO;
            stubIdx = NumSlicesCtr - 1;
          end
        end
        1: begin
          readyIn           = SP2V_LOW;
          newSlice          = stubCtr[stubIdx] + 16'd1;
          stubCtr[stubIdx]  = newSlice;
          weIdx = (stubMode == MODE_SKIP && stubIdx == NumSlicesCtr - 1) ? stubIdx - 1 : stubIdx;
          ctrIn[weIdx]      = newSlice;
          ctrWe[weIdx]      = SP2V_HIGH;
          if (stubMode == MODE_DOUBLE && stubIdx > 0) ctrWe[stubIdx-1] = SP2V_HIGH;
          if (newSlice != 16'd0 || stubIdx == 0) phase = 2;
          else stubIdx--;
        end
        default: begin
          readyIn = SP2V_HIGH;
          phase   = 0;
        end
      endcase
    end
  end

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rstI) begin
      incrCycles = 0;
    end else begin
      if (incrO == SP2V_HIGH) incrCycles++;
      if (ackO) begin
        if (expQ.size() == 0) begin
          checkOutput("ackWithoutRequest", 128'd1, 128'd0);
        end else begin
          checkOutput("ctrResult", ctrQ, expQ.pop_front());
          checkOutput("incrPulseLen", 128'(incrCycles), 128'd1);
          checkOutput("alertAtAck", 128'(alertO), 128'd0);
        end
        incrCycles = 0;
      end
    end
  end

  task automatic doReset();
    @(negedge clk);
    rstI      = 1'b1;
    reqI      = 1'b0;
    loadI     = 1'b0;
    stubMode  = MODE_NORMAL;
    holdReady = SP2V_HIGH;
    holdWeIdx = -1;
    repeat (3) @(negedge clk);
    expQ.delete();
    rstI = 1'b0;
  endtask

  task automatic startRequest(input logic [127:0] val, input bit collide);
    @(negedge clk);
    loadI    = 1'b1;
    loadData = val;
    reqI     = collide;
    @(negedge clk);
    loadI = 1'b0;
    reqI  = 1'b1;
  endtask

  task automatic loadOnly(input logic [127:0] val);
    @(negedge clk);
    loadI    = 1'b1;
    loadData = val;
    @(negedge clk);
    loadI = 1'b0;
  endtask

  task automatic applyStimulus(input logic [127:0] val, input bit collide);
    int waited = 0;
    startRequest(val, collide);
    if (collide) checkOutput("collideLoadFirst", 128'(busyO), 128'd0);
    expQ.push_back(val + 128'd1);
    do begin
      @(negedge clk);
      waited++;
    end while (!ackO && waited < 60);
    if (!ackO) checkOutput("ackTimeout", 128'd0, 128'd1);
    reqI = 1'b0;
  endtask

  task automatic checkAlert(input string name, input logic [127:0] expCtr, output int waited);
    waited = 0;
    while (!alertO && waited < 80) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({name, "Alert"}, 128'(alertO), 128'd1);
    checkOutput({name, "CtrKept"}, ctrQ, expCtr);
    repeat (3) @(negedge clk);
    checkOutput({name, "Sticky"}, 128'(alertO), 128'd1);
    checkOutput({name, "IncrLow"}, 128'(incrO), 128'(SP2V_LOW));
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "Ctr"}, ctrQ, 128'd0);
    checkOutput({name, "Busy"}, 128'(busyO), 128'd0);
    checkOutput({name, "Ack"}, 128'(ackO), 128'd0);
    checkOutput({name, "Alert"}, 128'(alertO), 128'd0);
    checkOutput({name, "Incr"}, 128'(incrO), 128'(SP2V_LOW));
  endtask

  initial begin
    logic [127:0] val;
    int           waited;
    int           k;
    rstI      = 1'b1;
    reqI      = 1'b0;
    loadI     = 1'b0;
    loadData  = '0;
    stubMode  = MODE_NORMAL;
    holdReady = SP2V_HIGH;
    holdWeIdx = -1;
    holdVal   = '0;

    doReset();
    checkResetState("reset");

    applyStimulus(128'd0, 1'b0);
    applyStimulus(128'hFFFF_FFFF, 1'b0);
    applyStimulus({128{1'b1}}, 1'b0);
    applyStimulus(128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 1'b1);

    for (int n = 0; n < 24; n++) begin
      val = {$urandom, $urandom, $urandom, $urandom};
      k   = $urandom_range(0, 8);
      for (int s = 0; s < k; s++) val[16*s +: 16] = 16'hFFFF;
      applyStimulus(val, 1'($urandom_range(0, 1)));
    end

    // Reset right after the first slice has been committed.
    doReset();
    val = {$urandom, $urandom, $urandom, 16'h1234, 16'hFFFF};
    startRequest(val, 1'b0);
    waited = 0;
    while (ctrQ == val && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("midFirstSlice", {val[127:16], 16'h0000}, ctrQ);
    rstI = 1'b1;
    reqI = 1'b0;
    @(negedge clk);
    checkResetState("midReset");
    repeat (2) @(negedge clk);
    expQ.delete();
    rstI = 1'b0;

    doReset();
    val = {$urandom, $urandom, $urandom, $urandom};
    loadOnly(val);
    stubMode  = MODE_HOLD;
    holdReady = sp2v_e'(3'b000);
    checkAlert("badReady", val, waited);

    doReset();
    val = {$urandom, $urandom, $urandom, $urandom};
    loadOnly(val);
    stubMode  = MODE_HOLD;
    holdWeIdx = 3;
    holdVal   = ~val[16*4 +: 16];
    checkAlert("weInIdle", val, waited);

    doReset();
    val = {$urandom, $urandom, $urandom, 16'h1234, 16'h5678};
    stubMode = MODE_SKIP;
    startRequest(val, 1'b0);
    checkAlert("outOfOrder", val, waited);

    doReset();
    val = {$urandom, $urandom, $urandom, 16'hAAAA, 16'h0042};
    stubMode = MODE_DOUBLE;
    startRequest(val, 1'b0);
    checkAlert("doubleWe", val, waited);

    doReset();
    val = {$urandom, $urandom, $urandom, $urandom};
    stubMode = MODE_NOREADY;
    startRequest(val, 1'b0);
    checkAlert("timeout", val, waited);
    checkOutput("timeoutNotEarly", 128'(waited >= TimeoutCycles), 128'd1);

    doReset();
    checkResetState("finalReset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
